proc_control_fsm: RTL
=====================

# proc_control_fsm

Control unit of the multi-cycle 9-bit processor. Decodes the instruction register and sequences the shared datapath bus one time-step per clock: bus-source selects for the bus multiplexer (one-hot register select, G select, DIN select), register/A/G/IR load enables, and the ALU add/subtract control. It sits beside the register file, A, G and IR registers and the bus multiplexer, and is the only block that drives their control inputs.

## Interface
- Parameters: none. Data width is 9 bits and the register count is 8.
- Clock  in  1  single system clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high; sampled on the rising edge of Clock.
- Run  in  1  start request; sampled only in state T0.
- IR  in  9  instruction register contents {III, XXX, YYY}: opcode, Rx index, Ry index.
- IRin  out  1  load enable for IR.
- Rin  out  8  one-hot load enable for R0..R7.
- SRout  out  8  one-hot bus-source select for R0..R7, to the bus multiplexer.
- SGout  out  1  bus-source select for G.
- SDout  out  1  bus-source select for DIN.
- Ain  out  1  load enable for A.
- Gin  out  1  load enable for G.
- AddSub  out  1  ALU control: 0 = A+bus, 1 = A−bus.
- Done  out  1  single-cycle pulse marking instruction completion.

## Operation
- States: T0 (fetch/idle), T1, T2, T3. Encoding is 2-bit binary; T0 = 2'b00.
- Outputs are combinational from the current state and IR. No output is registered.
- Opcodes: 000 mv Rx,Ry; 001 mvi Rx,#DIN; 010 add Rx,Ry; 011 sub Rx,Ry; 1xx reserved.
- T0: IRin = Run. If Run=1, go to T1; otherwise stay in T0.
- T1, mv: SRout = onehot(Y), Rin = onehot(X), Done = 1, then go to T0.
- T1, mvi: SDout = 1, Rin = onehot(X), Done = 1, then go to T0.
- T1, add/sub: SRout = onehot(X), Ain = 1, then go to T2.
- T1, reserved opcode: all strobes are 0, Done = 1, then go to T0. The reserved opcode acts as a NOP.
- T2 (add/sub only): SRout = onehot(Y), Gin = 1, AddSub = 1 for sub and 0 for add, then go to T3.
- T3 (add/sub only): SGout = 1, Rin = onehot(X), Done = 1, then go to T0.
- Any output not listed for a state/opcode is 0.
- Bus-driver exclusivity:
  - In every cycle at most one of {SRout≠0, SGout, SDout} is active.
  - SRout and Rin are each 0 or exactly one-hot.
- Run is ignored outside T0. IR must stay stable from T1 until Done; IR changes during T1–T3 are not protected.
- Rx = Ry is legal. For mv it is a no-op copy; for add/sub it yields 2·Rx or 0.
- Arithmetic wraps modulo 2^9 inside the ALU. The controller does no width handling.

## Timing
- Reset=1 at an edge: next state is T0. During any cycle where Reset=1, all outputs are forced to 0 regardless of state or Run.
- Reset mid-instruction (T1–T3): the instruction is aborted, no Done is issued, and the register writes of the remaining steps do not happen.
- Latency from the Run-sampled edge:
  - mv/mvi/reserved: Done appears in the next cycle (T1); two cycles total including T0.
  - add/sub: Done appears in T3; four cycles total.
- Back-to-back instructions: Run held at 1 re-enters T1 on the edge after Done, so there are no dead cycles beyond T0.
- Done lasts exactly one cycle per instruction.

## Structure
- Shared package proc_pkg holds:
  - opcode constants OP_MV, OP_MVI, OP_ADD, OP_SUB;
  - state constants T0..T3;
  - field-slice positions of IR (III = [8:6], XXX = [5:3], YYY = [2:0]).
- One sub-module, dec3to8, is instantiated twice: one-hot decode of X and of Y.
- The state register is a single always block on Clock. Output and next-state decode is a separate combinational block.

## Test plan
- Reset: hold Reset=1 for 2 cycles with Run=1 → state T0 and all outputs 0 throughout. Release with Run=0 → IRin=0, no Done.
- mvi R5: IR = 9'b001_101_000, Run=1 → T1: SDout=1, Rin=8'h20, Done=1. Next cycle: T0.
- mv R2,R7: IR = 9'b000_010_111 → T1: SRout=8'h80, Rin=8'h04, Done=1. Bus drivers stay exclusive.
- sub R1,R3: IR = 9'b011_001_011 →
  - T1: SRout=8'h02, Ain=1.
  - T2: SRout=8'h08, Gin=1, AddSub=1.
  - T3: SGout=1, Rin=8'h02, Done=1.
  - Repeat with opcode 010 and confirm AddSub=0 in T2.
- Reset in T2 of an add → next cycle is T0, no Done, no Rin pulse. A following mvi completes normally.
- Reserved opcode 9'b110_000_000 → T1: Done=1 with all strobes 0. Also check Run toggling during T1–T3 of an add has no effect on the sequence.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the 9-bit processor control unit: opcodes,
// time-step states and the IR field positions.
package proc_pkg;

  typedef enum logic [1:0] {
    T0 = 2'b00,
    T1 = 2'b01,
    T2 = 2'b10,
    T3 = 2'b11
  } state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  // IR = {III, XXX, YYY}
  localparam int III_HI = 8;
  localparam int III_LO = 6;
  localparam int XXX_HI = 5;
  localparam int XXX_LO = 3;
  localparam int YYY_HI = 2;
  localparam int YYY_LO = 0;

  // Opcodes with the top bit set are reserved and execute as a NOP.
  function automatic logic is_reserved(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/proc_control_fsm_dec3to8.sv
// 3-to-8 one-hot decoder used for the Rx and Ry register selects.
module dec3to8 (
  input  logic [2:0] sel_i,
  output logic [7:0] onehot_o
);

  // Exactly one bit set for every select value.
  always_comb begin
    onehot_o = 8'd1 << sel_i;
  end

endmodule

// File: rtl/proc_control_fsm.sv
// Control unit of the multi-cycle 9-bit processor. Steps through T0..T3,
// one bus transfer per clock, and drives the bus-source selects and the
// load enables of the register file, A, G and IR. All outputs are decoded
// combinationally from the current step and IR.
module proc_control_fsm
  import proc_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Run,
  input  logic [8:0] IR,
  output logic       IRin,
  output logic [7:0] Rin,
  output logic [7:0] SRout,
  output logic       SGout,
  output logic       SDout,
  output logic       Ain,
  output logic       Gin,
  output logic       AddSub,
  output logic       Done
);

  state_t     state_q;
  state_t     state_d;
  logic [2:0] op;
  logic [7:0] x_oh;
  logic [7:0] y_oh;

  assign op = IR[III_HI:III_LO];

  dec3to8 u_dec_x (
    .sel_i    (IR[XXX_HI:XXX_LO]),
    .onehot_o (x_oh)
  );

  dec3to8 u_dec_y (
    .sel_i    (IR[YYY_HI:YYY_LO]),
    .onehot_o (y_oh)
  );

  // State register: reset returns to fetch, aborting any instruction in flight.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= T0;
    end else begin
      state_q <= state_d;
    end
  end

  // Per-step output strobes and next-step decode; Reset blanks every strobe.
  always_comb begin
    state_d = state_q;
    IRin    = 1'b0;
    Rin     = 8'h00;
    SRout   = 8'h00;
    SGout   = 1'b0;
    SDout   = 1'b0;
    Ain     = 1'b0;
    Gin     = 1'b0;
    AddSub  = 1'b0;
    Done    = 1'b0;

    case (state_q)
      T0: begin
        IRin    = Run;
        state_d = Run ? T1 : T0;
      end
      T1: begin
        if (is_reserved(op)) begin
          Done    = 1'b1;
          state_d = T0;
        end else if (op == OP_MV) begin
          SRout   = y_oh;
          Rin     = x_oh;
          Done    = 1'b1;
          state_d = T0;
        end else if (op == OP_MVI) begin
          SDout   = 1'b1;
          Rin     = x_oh;
          Done    = 1'b1;
          state_d = T0;
        end else begin
          // add/sub: first operand Rx into A
          SRout   = x_oh;
          Ain     = 1'b1;
          state_d = T2;
        end
      end
      T2: begin
        // second operand Ry through the ALU into G
        SRout   = y_oh;
        Gin     = 1'b1;
        AddSub  = (op == OP_SUB);
        state_d = T3;
      end
      T3: begin
        // result G back into Rx
        SGout   = 1'b1;
        Rin     = x_oh;
        Done    = 1'b1;
        state_d = T0;
      end
      default: begin
        state_d = T0;
      end
    endcase

    if (Reset) begin
      IRin   = 1'b0;
      Rin    = 8'h00;
      SRout  = 8'h00;
      SGout  = 1'b0;
      SDout  = 1'b0;
      Ain    = 1'b0;
      Gin    = 1'b0;
      AddSub = 1'b0;
      Done   = 1'b0;
    end
  end

endmodule
